// File: rtl/accel_pkg.sv
// Shared accelerator types: vector data word, memory op codes and arbiter FSM states.
package accel_pkg;

  localparam int VECTOR_DEPTH = 4;
  localparam int VECTOR_WIDTH = 8;

  typedef logic [VECTOR_DEPTH-1:0][VECTOR_WIDTH-1:0] vector_data_t;

  typedef enum logic [3:0] {
    MEM_LOAD  = 4'b0001,
    MEM_STORE = 4'b0010,
    MEM_COMP  = 4'b0100
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE) || (op == MEM_COMP);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin request picker: first set req bit at or above rr_ptr, wrapping.
module rr_picker #(
  parameter int NUM_UNITS = 4,
  parameter int IDW       = 2
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [IDW-1:0]       rr_ptr,
  output logic [NUM_UNITS-1:0] pick,
  output logic [IDW-1:0]       id
);

  always_comb begin : search
    int   j;
    logic found;
    pick  = '0;
    id    = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      j = (int'(rr_ptr) + k) % NUM_UNITS;
      if (!found && req[j]) begin
        found   = 1'b1;
        pick[j] = 1'b1;
        id      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin vector-memory server with fixed access latency, one access in flight.
// Define MEM_ARB_STATS_EN to build the per-unit saturating grant counters.
module mem_arbiter
  import accel_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int MEM_DEPTH   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_UNITS-1:0]        req,
  input  logic [NUM_UNITS-1:0][3:0]   op_type,
  input  logic [NUM_UNITS-1:0][3:0]   vec_index,
  input  vector_data_t [NUM_UNITS-1:0] write_data,
  output logic [NUM_UNITS-1:0]        grant,
  output logic [NUM_UNITS-1:0]        done,
  output vector_data_t                read_data,
  output logic                        error,
  output logic                        busy,
  output logic [NUM_UNITS-1:0][15:0]  grant_count
);

  localparam int         IDW      = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int         AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  arb_state_t           state, state_d;
  logic [3:0]           lat_cnt, lat_d;
  logic [IDW-1:0]       rr_ptr, rr_d;
  logic [NUM_UNITS-1:0] pick, grant_d, done_d;
  logic [IDW-1:0]       pick_id;
  logic                 err_d, busy_d, latch_en, mem_we, legal;
  vector_data_t         rd_d;

  logic [IDW-1:0]       id_q;
  logic [3:0]           op_q;
  logic [3:0]           idx_q;
  vector_data_t         wd_q;
  logic [AW-1:0]        addr;

  vector_data_t         mem [MEM_DEPTH];

  rr_picker #(
    .NUM_UNITS (NUM_UNITS),
    .IDW       (IDW)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .id     (pick_id)
  );

  assign addr  = idx_q[AW-1:0];
  assign legal = op_is_legal(op_q) && (int'(idx_q) < MEM_DEPTH);

  always_comb begin
    state_d  = state;
    lat_d    = lat_cnt;
    rr_d     = rr_ptr;
    grant_d  = '0;
    done_d   = '0;
    err_d    = 1'b0;
    rd_d     = read_data;
    latch_en = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          latch_en = 1'b1;
          grant_d  = pick;
          lat_d    = LAT_INIT;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // The store lands on the first ACCESS edge so a later load sees it.
        if (lat_cnt == LAT_INIT && legal && op_q == MEM_STORE) mem_we = 1'b1;
        if (lat_cnt == 4'd0) begin
          state_d      = DONE;
          done_d[id_q] = 1'b1;
          if (!legal) begin
            err_d = 1'b1;
            rd_d  = '0;
          end else if (op_q != MEM_STORE) begin
            rd_d = mem[addr];
          end
        end else begin
          lat_d = lat_cnt - 4'd1;
        end
      end
      DONE: begin
        rr_d    = (id_q == IDW'(NUM_UNITS - 1)) ? '0 : id_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      done      <= '0;
      error     <= 1'b0;
      busy      <= 1'b0;
      read_data <= '0;
    end else begin
      state     <= state_d;
      lat_cnt   <= lat_d;
      rr_ptr    <= rr_d;
      grant     <= grant_d;
      done      <= done_d;
      error     <= err_d;
      busy      <= busy_d;
      read_data <= rd_d;
    end
  end

  // Latched request fields are only consumed after IDLE has loaded them.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      id_q  <= pick_id;
      op_q  <= op_type[pick_id];
      idx_q <= vec_index[pick_id];
      wd_q  <= write_data[pick_id];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr] <= wd_q;
    end
  end

`ifdef MEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (grant[i]) grant_count[i] <= sat_inc16(grant_count[i]);
      end
    end
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus multi-cycle corner sequences.
module tb_mem_arbiter;
  import accel_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [3:0]             req = '0;
  logic [3:0][3:0]        op_type = '0;
  logic [3:0][3:0]        vec_index = '0;
  vector_data_t [3:0]     write_data = '0;
  logic [3:0]             grant, done;
  vector_data_t           read_data;
  logic                   error, busy;
  logic [3:0][15:0]       grant_count;

  logic [3:0]             req8 = '0;
  logic [3:0][3:0]        op8 = '0;
  logic [3:0][3:0]        idx8 = '0;
  vector_data_t [3:0]     wd8 = '0;
  logic [3:0]             grant8, done8;
  vector_data_t           rd8;
  logic                   err8, busy8;
  logic [3:0][15:0]       gc8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.NUM_UNITS(4), .MEM_DEPTH(16), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_type(op_type), .vec_index(vec_index),
    .write_data(write_data), .grant(grant), .done(done), .read_data(read_data),
    .error(error), .busy(busy), .grant_count(grant_count)
  );

  mem_arbiter #(.NUM_UNITS(4), .MEM_DEPTH(8), .MEM_LATENCY(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .op_type(op8), .vec_index(idx8),
    .write_data(wd8), .grant(grant8), .done(done8), .read_data(rd8),
    .error(err8), .busy(busy8), .grant_count(gc8)
  );

  typedef struct {
    int           unit;
    logic [3:0]   op;
    logic [3:0]   idx;
    vector_data_t wd;
    bit           err;
    vector_data_t rd;
  } vec_t;

  vec_t tbl[11];
  int   order[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req   = '0;
    req8  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic txn(input int u, input logic [3:0] op, input logic [3:0] ix,
                     input vector_data_t wd, input bit exp_err, input vector_data_t exp_rd);
    int c;
    req           = '0;
    req[u]        = 1'b1;
    op_type[u]    = op;
    vec_index[u]  = ix;
    write_data[u] = wd;
    @(negedge clk);
    check("grant", 64'(grant), 64'(1 << u));
    check("busy_at_grant", 64'(busy), 64'd1);
    c = 1;
    while (done == '0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("done_cycle", 64'(c), 64'd3);
    check("done", 64'(done), 64'(1 << u));
    check("error", 64'(error), 64'(exp_err));
    check("read_data", 64'(read_data), 64'(exp_rd));
    req = '0;
    @(negedge clk);
    check("pulse_end", 64'({done, error, busy}), 64'd0);
  endtask

  initial begin
    int c;
    int nd;
    int prev_done;
    logic [15:0] exp_gc;

    tbl[0]  = '{1, MEM_STORE, 4'd3,  32'hA5A5A5A5, 1'b0, 32'h00000000};
    tbl[1]  = '{2, MEM_LOAD,  4'd3,  32'h00000000, 1'b0, 32'hA5A5A5A5};
    tbl[2]  = '{3, MEM_STORE, 4'd7,  32'h12345678, 1'b0, 32'hA5A5A5A5};
    tbl[3]  = '{0, MEM_COMP,  4'd7,  32'h00000000, 1'b0, 32'h12345678};
    tbl[4]  = '{0, 4'b1000,   4'd3,  32'hFFFFFFFF, 1'b1, 32'h00000000};
    tbl[5]  = '{1, MEM_LOAD,  4'd3,  32'h00000000, 1'b0, 32'hA5A5A5A5};
    tbl[6]  = '{2, 4'b0011,   4'd7,  32'hCAFEF00D, 1'b1, 32'h00000000};
    tbl[7]  = '{3, MEM_LOAD,  4'd7,  32'h00000000, 1'b0, 32'h12345678};
    tbl[8]  = '{2, MEM_STORE, 4'd15, 32'hDEADBEEF, 1'b0, 32'h12345678};
    tbl[9]  = '{1, MEM_LOAD,  4'd15, 32'h00000000, 1'b0, 32'hDEADBEEF};
    tbl[10] = '{0, MEM_LOAD,  4'd0,  32'h00000000, 1'b0, 32'h00000000};
    order   = '{0, 1, 2, 3, 0};

    // reset state, sampled while rst_n is low
    @(negedge clk);
    check("rst_outputs", 64'({grant, done, error, busy}), 64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("rst_grant_count", 64'(grant_count), 64'd0);
    do_reset();

    for (int i = 0; i < 11; i++)
      txn(tbl[i].unit, tbl[i].op, tbl[i].idx, tbl[i].wd, tbl[i].err, tbl[i].rd);

    // all four units request continuously
    do_reset();
    for (int u = 0; u < 4; u++) begin
      op_type[u]   = MEM_LOAD;
      vec_index[u] = 4'(u);
    end
    req = 4'b1111;
    prev_done = 0;
    for (int g = 0; g < 5; g++) begin
      c = 0;
      while (grant == '0 && c < 20) begin @(negedge clk); c++; end
      check("rr_grant", 64'(grant), 64'(1 << order[g]));
      c = 0;
      while (done == '0 && c < 20) begin @(negedge clk); c++; end
      check("rr_done", 64'(done), 64'(1 << order[g]));
      if (g > 0) check("rr_period", 64'(cyc - prev_done), 64'd4);
      prev_done = cyc;
      if (g == 4) req = '0;
      @(negedge clk);
    end

    // reset during the first ACCESS cycle of a store
    req           = 4'b1000;
    op_type[3]    = MEM_STORE;
    vec_index[3]  = 4'd5;
    write_data[3] = 32'h55555555;
    @(negedge clk);
    check("rst_mid_grant", 64'(grant), 64'h8);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_grant_clr", 64'(grant), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done != '0) nd++;
    end
    check("rst_mid_no_done", 64'(nd), 64'd0);
    op_type[0]   = MEM_LOAD;
    vec_index[0] = 4'd5;
    op_type[1]   = MEM_LOAD;
    vec_index[1] = 4'd5;
    req = 4'b0011;
    c = 0;
    while (grant == '0 && c < 20) begin @(negedge clk); c++; end
    check("rst_mid_next_grant", 64'(grant), 64'h1);
    c = 0;
    while (done == '0 && c < 20) begin @(negedge clk); c++; end
    check("rst_mid_done", 64'(done), 64'h1);
    check("rst_mid_mem5", 64'(read_data), 64'd0);
    req = '0;
    @(negedge clk);

    // grant statistics
    do_reset();
    repeat (3) txn(2, MEM_LOAD, 4'd1, 32'h0, 1'b0, 32'h0);
`ifdef MEM_ARB_STATS_EN
    exp_gc = 16'd3;
`else
    exp_gc = 16'd0;
`endif
    check("grant_count2", 64'(grant_count[2]), 64'(exp_gc));
    check("grant_count0", 64'(grant_count[0]), 64'd0);

    // MEM_DEPTH = 8 instance: out-of-range and last legal index
    req8    = 4'b0001;
    op8[0]  = MEM_LOAD;
    idx8[0] = 4'd12;
    c = 0;
    while (done8 == '0 && c < 20) begin @(negedge clk); c++; end
    check("d8_done", 64'(done8), 64'h1);
    check("d8_error", 64'(err8), 64'd1);
    check("d8_read_data", 64'(rd8), 64'd0);
    req8 = '0;
    @(negedge clk);
    req8    = 4'b0001;
    idx8[0] = 4'd7;
    c = 0;
    while (done8 == '0 && c < 20) begin @(negedge clk); c++; end
    check("d8_legal_done", 64'(done8), 64'h1);
    check("d8_legal_error", 64'(err8), 64'd0);
    req8 = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared vector-memory server directly downstream of the compute units' memory ports. It accepts load, store and compute-fetch requests from up to NUM_UNITS units, and arbitrates them round-robin. Each granted request is served against an internal vector register file, with a fixed access latency. Results return on a broadcast read bus with a one-cycle per-unit done pulse, and at most one access is in flight at a time.

## Interface
- NUM_UNITS, 4, number of requesting units (unit id = array index)
- MEM_DEPTH, 16, number of vector_data_t entries; must be ≤ 16 (4-bit index)
- MEM_LATENCY, 2, cycles from grant to done; legal range 1..15
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_UNITS  per-unit mem_request
- op_type  in  NUM_UNITS×4  per-unit op: 0001 load, 0010 store, 0100 compute-fetch
- vec_index  in  NUM_UNITS×4  per-unit entry index
- write_data  in  NUM_UNITS×vector_data_t  per-unit store data
- grant  out  NUM_UNITS  one-hot, one-cycle pulse when a request is accepted
- done  out  NUM_UNITS  one-hot, one-cycle completion pulse
- read_data  out  vector_data_t  broadcast result, valid in the done cycle, held until the next done
- error  out  1  one-cycle pulse, coincident with done, for an illegal op or out-of-range index
- busy  out  1  high in every state except IDLE
- grant_count  out  NUM_UNITS×16  per-unit served-request counters (see Configuration)

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set: select the first set bit starting at rr_ptr, searching upward and wrapping modulo NUM_UNITS.
  - Latch the unit id, op, index and write data.
  - Pulse grant[id] in the next cycle.
  - Go to ACCESS and load lat_cnt = MEM_LATENCY-1.
- ACCESS:
  - First cycle: a store writes mem[index] <= latched data at the closing edge.
  - Each cycle: lat_cnt decrements.
  - When lat_cnt = 0: go to DONE. Load and compute-fetch register read_data <= mem[index] at that edge.
- DONE:
  - Pulse done[id].
  - Update rr_ptr = (id+1) mod NUM_UNITS.
  - Return to IDLE.
- Store: read_data is unchanged, and done still pulses.
- Illegal op (any code other than 0001, 0010, 0100) or index ≥ MEM_DEPTH:
  - No memory write.
  - read_data <= '0.
  - error and done pulse together.
- Requests are sampled only in IDLE.
  - A req that drops after grant does not abort the access; it completes normally.
  - A req bit must be held until its done. The unit deasserts req in the cycle after done, so IDLE never re-grants a stale request.
- Simultaneous requests are served strictly in round-robin order. A store and a load to the same index from different units take effect in service order.
- No bypass: a load issued after a store observes the stored value.

## Timing
- Reset, asynchronous: state = IDLE, rr_ptr = 0, lat_cnt = 0, all mem entries = '0.
- Output reset values: grant = 0, done = 0, error = 0, busy = 0, read_data = '0, grant_count = 0.
- All outputs are registered.
- Request latency:
  - req visible in cycle 0 (IDLE) gives grant in cycle 1 and done in cycle MEM_LATENCY+1.
  - Default: done in cycle 3.
- Back-to-back throughput: with req held by another unit, its grant comes in the cycle after the previous done. Every access occupies MEM_LATENCY+2 cycles, including IDLE.
- Reset asserted mid-access: the access is discarded, no done pulse is issued, and a partially counted store is not written if reset precedes the write edge.
- busy is high from the grant cycle through the done cycle inclusive.

## Configuration
- MEM_ARB_STATS_EN defined:
  - grant_count[i] increments by 1 on each grant[i].
  - It saturates at 16'hFFFF.
  - It resets to 0.
- MEM_ARB_STATS_EN undefined: the counters are not built and grant_count is tied to '0.
- All other behaviour is identical in both builds.

## Structure
- Shared accel_pkg holds:
  - vector_data_t, VECTOR_DEPTH, VECTOR_WIDTH (existing).
  - New enum mem_op_t: MEM_LOAD=4'b0001, MEM_STORE=4'b0010, MEM_COMP=4'b0100.
  - New enum arb_state_t: IDLE, ACCESS, DONE.
- Sub-module rr_picker is natural. It is purely combinational: inputs req and rr_ptr, outputs a one-hot pick and a binary id.
- The FSM, latency counter, register file and stats counters stay in mem_arbiter.

## Test plan
- Reset, then unit 1 stores 0xA5-pattern vector at index 3; later unit 2 loads index 3 -> grant[1] in cycle 1 and done[1] in cycle 3; done[2] returns the 0xA5 vector on read_data.
- req = 4'b1111 held, all loads -> grants in order 0,1,2,3,0; each done is 4 cycles after the previous done.
- Unit 0 op_type = 4'b1000 -> done[0] and error pulse together, read_data = '0, memory unchanged.
- MEM_DEPTH = 8, load index 12 -> error = 1, read_data = '0.
- rst_n pulsed low in ACCESS of a store to index 5 -> no done pulse, mem[5] = 0, busy = 0, next grant goes to the lowest requesting unit.
- With MEM_ARB_STATS_EN, 3 grants to unit 2 -> grant_count[2] = 3; without the macro, grant_count stays 0.
